// File: rtl/kicp_sram_arbiter_pkg.sv
// Shared definitions for the KICP SRAM arbiter slice.
//   - mem_op encodings used by every requester
//   - SRAM word-address width
//   - requester indices
//   - arbiter FSM state type
`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 8
`endif

package kicp_defs;

    localparam int KICP_SRAM_AWIDTH = `KICP_SRAM_AWIDTH;

    localparam logic [1:0] MEMOP_NONE  = 2'b00;
    localparam logic [1:0] MEMOP_READ  = 2'b01;
    localparam logic [1:0] MEMOP_WRITE = 2'b11;

    localparam logic [1:0] REQ_HOST  = 2'd0;
    localparam logic [1:0] REQ_MMUL  = 2'd1;
    localparam logic [1:0] REQ_MCONV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // 2'b10 is not a legal op and is treated exactly like idle.
    function automatic logic op_valid(input logic [1:0] op);
        return (op == MEMOP_READ) || (op == MEMOP_WRITE);
    endfunction

endpackage

// File: rtl/kicp_sram_arbiter_rr_pick.sv
// kicp_rr_pick: combinational rotating priority encoder.
// Ports:
//   i_valid       per-requester valid request
//   i_last_grant  index of the most recent grant (search starts after it)
//   o_grant       winning requester index
//   o_any_valid   at least one requester is valid
// With HOST_PRIO=1 requester 0 (the host) pre-empts the rotation.
module kicp_rr_pick #(
    parameter int NREQ      = 3,
    parameter bit HOST_PRIO = 1'b1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [1:0]      i_last_grant,
    output logic [1:0]      o_grant,
    output logic            o_any_valid
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant     = 2'd0;
        o_any_valid = |i_valid;
        w_found     = 1'b0;
        w_idx       = 0;

        // Host index is 0; it wins outright when host priority is enabled.
        if (HOST_PRIO && i_valid[0]) begin
            o_grant = 2'd0;
            w_found = 1'b1;
        end

        // Search last_grant+1, last_grant+2, ... wrapping modulo NREQ.
        // With host priority the host is already known idle here, so the
        // same rotation covers requesters 1..NREQ-1 only.
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = (int'(i_last_grant) + off) % NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && (j == w_idx) && i_valid[j]) begin
                    o_grant = 2'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kicp_sram_arbiter.sv
// kicp_sram_arbiter: fixed-latency arbiter for the single-port RAM256 macro.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req_op_i            per-requester mem_op (2 bits each)
//   req_addr_i          per-requester word address
//   req_wdata_i         per-requester write data
//   req_done_o          one-cycle completion pulse to the granted requester
//   rdata_o             read data, updated when a read completes
//   sram_*              RAM256 EN0 / WE0 / A0 / Di0 / Do0
//   busy_o              an operation is in flight
//   grant_o             current / last granted requester
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | sample requests, pick a winner, load SRAM command regs
// ST_ISSUE | macro samples EN/WE/A/Di at the end of this cycle
// ST_WAIT  | macro output valid; capture read data, arm done pulse
// ST_DONE  | done pulse visible; requester drops its op at this edge
module kicp_sram_arbiter
    import kicp_defs::*;
#(
    parameter int NREQ      = 3,
    parameter int AWIDTH    = KICP_SRAM_AWIDTH,
    parameter int DWIDTH    = 32,
    parameter bit HOST_PRIO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2*NREQ-1:0]        req_op_i,
    input  logic [AWIDTH*NREQ-1:0]   req_addr_i,
    input  logic [DWIDTH*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]          req_done_o,
    output logic [DWIDTH-1:0]        rdata_o,
    output logic                     sram_en_o,
    output logic [3:0]               sram_we_o,
    output logic [AWIDTH-1:0]        sram_addr_o,
    output logic [DWIDTH-1:0]        sram_wdata_o,
    input  logic [DWIDTH-1:0]        sram_rdata_i,
    output logic                     busy_o,
    output logic [1:0]               grant_o
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [1:0]          r_last_grant;
    logic [1:0]          r_grant;
    logic                r_is_read;
    logic                r_sram_en;
    logic [3:0]          r_sram_we;
    logic [AWIDTH-1:0]   r_sram_addr;
    logic [DWIDTH-1:0]   r_sram_wdata;
    logic [DWIDTH-1:0]   r_rdata;
    logic [NREQ-1:0]     r_done;

    logic [NREQ-1:0]     w_valid;
    logic [1:0]          w_pick;
    logic                w_any_valid;
    logic [1:0]          w_sel_op;
    logic [AWIDTH-1:0]   w_sel_addr;
    logic [DWIDTH-1:0]   w_sel_wdata;
    logic                w_sel_write;
    logic [NREQ-1:0]     w_grant_onehot;
    logic                w_load;
    logic                w_capture;
    logic                w_pulse;

    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            w_valid[j] = op_valid(req_op_i[2*j +: 2]);
        end
    end

    kicp_rr_pick #(
        .NREQ      (NREQ),
        .HOST_PRIO (HOST_PRIO)
    ) u_pick (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_any_valid  (w_any_valid)
    );

    always_comb begin
        w_sel_op    = MEMOP_NONE;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (int'(w_pick) == j) begin
                w_sel_op    = req_op_i[2*j +: 2];
                w_sel_addr  = req_addr_i[AWIDTH*j +: AWIDTH];
                w_sel_wdata = req_wdata_i[DWIDTH*j +: DWIDTH];
            end
        end
        w_sel_write = (w_sel_op == MEMOP_WRITE);
    end

    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            w_grant_onehot[j] = (int'(r_grant) == j);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                w_pulse     = 1'b1;
                w_capture   = r_is_read;
                w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 2'(NREQ - 1);
            r_grant      <= 2'd0;
            r_is_read    <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 4'h0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_rdata      <= '0;
            r_done       <= '0;
        end else begin
            // EN/WE are high only in the ISSUE cycle that follows a load.
            r_sram_en <= w_load;
            r_sram_we <= (w_load && w_sel_write) ? 4'hF : 4'h0;
            if (w_load) begin
                r_sram_addr  <= w_sel_addr;
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_is_read    <= !w_sel_write;
                if (w_sel_write) begin
                    r_sram_wdata <= w_sel_wdata;
                end
            end
            if (w_capture) begin
                r_rdata <= sram_rdata_i;
            end
            r_done <= w_pulse ? w_grant_onehot : '0;
        end
    end

    // Reset kills the macro strobes in the reset cycle itself, not one later.
    assign sram_en_o    = r_sram_en & ~reset;
    assign sram_we_o    = r_sram_we & {4{~reset}};
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;
    assign rdata_o      = r_rdata;
    assign req_done_o   = r_done;
    assign busy_o       = (r_state != ST_IDLE);
    assign grant_o      = r_grant;

endmodule

// File: tb/tb_kicp_sram_arbiter.sv
module tb_kicp_sram_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Round-robin instance (HOST_PRIO=0)
    logic [2*NREQ-1:0]  op_r;
    logic [AW*NREQ-1:0] addr_r;
    logic [DW*NREQ-1:0] wd_r;
    logic [NREQ-1:0]    done_r;
    logic [DW-1:0]      rdata_r, wdo_r, rdi_r;
    logic               en_r, busy_r;
    logic [3:0]         we_r;
    logic [AW-1:0]      ao_r;
    logic [1:0]         grant_r;

    // Host-priority instance (HOST_PRIO=1)
    logic [2*NREQ-1:0]  op_h;
    logic [AW*NREQ-1:0] addr_h;
    logic [DW*NREQ-1:0] wd_h;
    logic [NREQ-1:0]    done_h;
    logic [DW-1:0]      rdata_h, wdo_h, rdi_h;
    logic               en_h, busy_h;
    logic [3:0]         we_h;
    logic [AW-1:0]      ao_h;
    logic [1:0]         grant_h;

    kicp_sram_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .HOST_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .req_op_i(op_r), .req_addr_i(addr_r), .req_wdata_i(wd_r),
        .req_done_o(done_r), .rdata_o(rdata_r),
        .sram_en_o(en_r), .sram_we_o(we_r), .sram_addr_o(ao_r),
        .sram_wdata_o(wdo_r), .sram_rdata_i(rdi_r),
        .busy_o(busy_r), .grant_o(grant_r)
    );

    kicp_sram_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .HOST_PRIO(1'b1)) u_hp (
        .clk(clk), .reset(reset),
        .req_op_i(op_h), .req_addr_i(addr_h), .req_wdata_i(wd_h),
        .req_done_o(done_h), .rdata_o(rdata_h),
        .sram_en_o(en_h), .sram_we_o(we_h), .sram_addr_o(ao_h),
        .sram_wdata_o(wdo_h), .sram_rdata_i(rdi_h),
        .busy_o(busy_h), .grant_o(grant_h)
    );

    // RAM256 models: write or read on the rising edge while EN is high.
    logic [DW-1:0] mem_r [0:255];
    logic [DW-1:0] mem_h [0:255];
    always @(posedge clk) begin
        if (en_r) begin
            if (we_r == 4'hF) mem_r[ao_r] <= wdo_r;
            else              rdi_r       <= mem_r[ao_r];
        end
        if (en_h) begin
            if (we_h == 4'hF) mem_h[ao_h] <= wdo_h;
            else              rdi_h       <= mem_h[ao_h];
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] last_rd;

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];
    int   seq_rr [6];
    int   seq_hp [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single transaction on u_rr, starting in an IDLE cycle.
    task automatic run_single(input int req, input logic [1:0] op, input logic [7:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input bit chg, input logic [7:0] alt);
        int            done_cyc;
        int            en_cnt;
        logic [7:0]    seen_addr;
        logic [3:0]    seen_we;
        logic [NREQ-1:0] seen_done;
        logic [DW-1:0] exp_out;
        op_r[2*req +: 2]  = op;
        addr_r[8*req +: 8] = addr;
        wd_r[32*req +: 32] = wd;
        done_cyc  = -1;
        en_cnt    = 0;
        seen_addr = '0;
        seen_we   = '0;
        seen_done = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1 && chg) addr_r[8*req +: 8] = alt;
            if (en_r) begin
                en_cnt++;
                seen_addr = ao_r;
                seen_we   = we_r;
            end
            if (done_r != '0) begin
                if (done_cyc < 0) done_cyc = c;
                seen_done = done_r;
                op_r[2*req +: 2] = 2'b00;
            end
        end
        op_r[2*req +: 2] = 2'b00;
        exp_out = (op == 2'b01) ? exp_rd : last_rd;
        if (op == 2'b01) last_rd = exp_rd;
        chk("latency", 64'(done_cyc), 64'd3);
        chk("en_cycles", 64'(en_cnt), 64'd1);
        chk("sram_addr", 64'(seen_addr), 64'(addr));
        chk("sram_we", 64'(seen_we), (op == 2'b11) ? 64'hF : 64'h0);
        chk("done_vec", 64'(seen_done), 64'(1 << req));
        chk("grant", 64'(grant_r), 64'(req));
        chk("rdata", 64'(rdata_r), 64'(exp_out));
    endtask

    // All three requesters hold reads; compare the first six grants.
    task automatic collect(input bit hp, input int exp_seq[6], input int drop_after);
        int got;
        int last_c;
        logic [NREQ-1:0] d;
        got    = 0;
        last_c = -1;
        if (hp) op_h = 6'b010101;
        else    op_r = 6'b010101;
        for (int c = 0; c < 60 && got < 6; c++) begin
            tick();
            d = hp ? done_h : done_r;
            if (d != '0) begin
                chk(hp ? "hp_grant" : "rr_grant", 64'(d), 64'(1 << exp_seq[got]));
                if (last_c >= 0) chk("grant_interval", 64'(c - last_c), 64'd4);
                last_c = c;
                got++;
                if (got == drop_after) begin
                    if (hp) op_h[1:0] = 2'b00;
                    else    op_r[1:0] = 2'b00;
                end
            end
        end
        chk("grant_count", 64'(got), 64'd6);
        op_r = '0;
        op_h = '0;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit en_seen;
        bit busy_seen;

        vecs[0] = '{0, 2'b11, 8'h05, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 2'b01, 8'h05, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1, 2'b11, 8'hA0, 32'h12345678, 32'h0};
        vecs[3] = '{2, 2'b11, 8'hFF, 32'hCAFEF00D, 32'h0};
        vecs[4] = '{2, 2'b01, 8'hA0, 32'h0,        32'h12345678};
        vecs[5] = '{1, 2'b01, 8'hFF, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{0, 2'b11, 8'h00, 32'h00000001, 32'h0};
        vecs[7] = '{1, 2'b01, 8'h00, 32'h0,        32'h00000001};
        seq_rr = '{0, 1, 2, 0, 1, 2};
        seq_hp = '{0, 0, 0, 1, 2, 1};

        reset   = 1'b1;
        op_r    = '0; addr_r = '0; wd_r = '0;
        op_h    = '0; addr_h = {8'hFF, 8'hA0, 8'h05}; wd_h = '0;
        last_rd = '0;
        repeat (3) tick();

        chk("rst_done",  64'(done_r),  64'd0);
        chk("rst_rdata", 64'(rdata_r), 64'd0);
        chk("rst_en",    64'(en_r),    64'd0);
        chk("rst_we",    64'(we_r),    64'd0);
        chk("rst_addr",  64'(ao_r),    64'd0);
        chk("rst_wdata", 64'(wdo_r),   64'd0);
        chk("rst_busy",  64'(busy_r),  64'd0);
        chk("rst_grant", 64'(grant_r), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].req, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_rdata, 1'b0, 8'h00);
        end

        // Illegal op 2'b10 on every requester must never start a cycle.
        op_r      = 6'b101010;
        en_seen   = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            tick();
            if (en_r)   en_seen   = 1'b1;
            if (busy_r) busy_seen = 1'b1;
        end
        op_r = '0;
        chk("inv_en",   64'(en_seen),   64'd0);
        chk("inv_busy", 64'(busy_seen), 64'd0);

        // Address changed during ISSUE must not affect the op in flight.
        run_single(1, 2'b01, 8'hA0, 32'h0, 32'h12345678, 1'b1, 8'hFF);
        addr_r = '0;

        // Reset during ISSUE: EN forced low in the reset cycle.
        op_r[1:0]  = 2'b01;
        addr_r[7:0] = 8'h05;
        tick();
        chk("issue_en", 64'(en_r), 64'd1);
        reset = 1'b1;
        op_r  = '0;
        #1;
        chk("rst_issue_en", 64'(en_r), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Reset during WAIT: no done pulse, outputs cleared.
        op_r[1:0]  = 2'b01;
        addr_r[7:0] = 8'h05;
        tick();
        tick();
        chk("wait_busy", 64'(busy_r), 64'd1);
        reset = 1'b1;
        op_r  = '0;
        tick();
        chk("rw_done",  64'(done_r),  64'd0);
        chk("rw_rdata", 64'(rdata_r), 64'd0);
        chk("rw_busy",  64'(busy_r),  64'd0);
        chk("rw_grant", 64'(grant_r), 64'd0);
        chk("rw_en",    64'(en_r),    64'd0);
        reset   = 1'b0;
        last_rd = '0;
        tick();
        run_single(2, 2'b01, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00);

        // Round-robin from a fresh reset (last_grant = 2, so 0 goes first).
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        addr_r = {8'hFF, 8'hA0, 8'h05};
        collect(1'b0, seq_rr, -1);

        // Host priority: host re-requests for three grants, then goes idle.
        collect(1'b1, seq_hp, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
